// File: rtl/button_event_encoder.sv
// Synchronises, debounces and edge-detects four active-low buttons and emits a
// one-cycle, one-cold direction code per press. Define AUTO_REPEAT_EN for held-button repeats.
module button_event_encoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn_n,
  output logic [3:0] move_code,
  output logic       move_valid,
  output logic [3:0] btn_state
);

  localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 2 || REPEAT_PERIOD < 1) begin : g_bad_params
    $error("button_event_encoder: parameter out of range");
  end

  logic [3:0]    sync_q;
  logic [3:0]    sync_n;
  logic [3:0]    btn_prev;
  logic [CW-1:0] db_cnt [4];
  logic [3:0]    press;
  logic [3:0]    evt;
  logic [3:0]    next_code;

  // Two-flop synchroniser; idle level is 1 so reset does not fake a press.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      sync_n <= '1;
    end else begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      sync_q <= btn_n;
      sync_n <= sync_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_state <= '1;
      btn_prev  <= '1;
      // NOTE: the counter array is small and must restart on reset, so it is cleared explicitly.
      for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
    end else begin
      btn_prev <= btn_state;
      for (int i = 0; i < 4; i++) begin
        if (sync_n[i] == btn_state[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          btn_state[i] <= sync_n[i];
          db_cnt[i]    <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is a 1->0 transition of the debounced level; releases are ignored.
  assign press = btn_prev & ~btn_state;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX);

  logic [RW-1:0] rpt_cnt [4];
  logic [3:0]    rpt_on;
  logic [3:0]    rpt_hit;

  always_comb begin
    rpt_hit = '0;
    for (int i = 0; i < 4; i++) begin
      if (!btn_state[i]) begin
        rpt_hit[i] = rpt_on[i] ? (rpt_cnt[i] == RW'(REPEAT_PERIOD - 1))
                               : (rpt_cnt[i] == RW'(REPEAT_DELAY - 1));
      end
    end
  end

  // Repeat counters keep running even when their event loses arbitration.
  always_ff @(posedge clk) begin
    if (reset) begin
      rpt_on <= '0;
      for (int i = 0; i < 4; i++) rpt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (btn_state[i]) begin
          rpt_cnt[i] <= '0;
          rpt_on[i]  <= 1'b0;
        end else if (rpt_hit[i]) begin
          rpt_cnt[i] <= '0;
          rpt_on[i]  <= 1'b1;
        end else begin
          rpt_cnt[i] <= rpt_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Any fresh press outranks every repeat in the same cycle.
  assign evt = (press != 4'b0000) ? press : rpt_hit;
`else
  assign evt = press;
`endif

  // NOTE: next_code gets a default first so no path through the if-chain infers a latch.
  always_comb begin
    next_code = 4'b1111;
    if      (evt[3]) next_code = 4'b0111;
    else if (evt[2]) next_code = 4'b1011;
    else if (evt[1]) next_code = 4'b1101;
    else if (evt[0]) next_code = 4'b1110;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      move_code  <= 4'b1111;
      move_valid <= 1'b0;
    end else begin
      move_code  <= next_code;
      move_valid <= |evt;
    end
  end

endmodule

// File: doc/button_event_encoder.md
Name: button_event_encoder

Overview:
- Conditions the four raw active-low board push-buttons for the Buscaminas cursor logic.
- Synchronises, debounces and edge-detects each button, then emits a single-cycle, active-low, one-cold direction code per press, with a fixed priority between buttons.
- Sits between the board button pins and the cursor movement logic, which steps X/Y once per code.

Parameters:
- DEBOUNCE_CYCLES, 500000, clocks a synchronised level must be stable before it is accepted (10 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, clocks a button must be held before the first auto-repeat event (AUTO_REPEAT_EN only).
- REPEAT_PERIOD, 10000000, clocks between later auto-repeat events (AUTO_REPEAT_EN only).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- btn_n  input  4  raw buttons, active-low, asynchronous; bit3=up, bit2=left, bit1=down, bit0=right
- move_code  output  4  one-cold event code: 0111 up, 1011 left, 1101 down, 1110 right, 1111 idle
- move_valid  output  1  high for exactly the cycles move_code is not 1111
- btn_state  output  4  debounced levels, active-low, same bit order as btn_n

Behaviour:
- Reset is synchronous, active-high, and resets:
  - synchroniser flops to 1
  - btn_state to 1111
  - all debounce/repeat counters to 0
  - move_code to 1111
  - move_valid to 0
- Synchroniser: two flops per bit.
  - sync_n is the second-stage output.
- Debounce, per bit, independent:
  - If sync_n == btn_state, the counter clears to 0.
  - Otherwise the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 while still differing, btn_state takes sync_n on that edge and the counter clears.
  - Counter width is $clog2(DEBOUNCE_CYCLES).
- Press event: btn_state bit falls 1->0. Release (0->1) produces no event.
- Output register:
  - On the edge after a press event, move_code = the code for that button and move_valid = 1, for exactly one cycle.
  - Otherwise move_code = 1111 and move_valid = 0.
- Latency: a clean raw level change first sampled at edge t gives move_valid high during the cycle after edge t+2+DEBOUNCE_CYCLES.
- Simultaneous press events in the same cycle:
  - Priority is up > left > down > right.
  - Lower-priority events are dropped, not queued.
  - Their btn_state bits still update.
- Glitches stable for fewer than DEBOUNCE_CYCLES clocks: no btn_state change, no event.
- Button held through reset release: btn_state starts at 1, so the held level debounces normally and produces exactly one press event.
- Reset asserted mid-debounce: the count is abandoned, and any pending output pulse is cancelled that edge.
- Back-to-back events on different buttons are allowed on consecutive cycles; no minimum gap.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - Each button has a repeat counter that runs while its btn_state bit is 0 and clears when it is 1.
  - The first repeat event fires when the counter reaches REPEAT_DELAY-1.
  - Later repeats fire every REPEAT_PERIOD clocks while the button is held.
  - A repeat event is a press event for that button and joins the same priority arbitration.
  - A fresh press of any button beats all repeat events that cycle.
  - A dropped repeat is not retried; the counter continues.
- Undefined:
  - There is no repeat logic.
  - Exactly one event per debounced press.
  - The REPEAT_* parameters are ignored.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8):
- Reset asserted with btn_n=1111 -> move_code=1111, move_valid=0, btn_state=1111 on the following edge.
- btn_n 1111->0111 held 20 cycles -> one pulse of move_code=0111, move_valid=1, exactly 7 cycles after the change edge; btn_state=0111; no further pulse; release gives no pulse.
- btn_n=1011 for 3 cycles, then 1111 -> no pulse, btn_state stays 1111.
- btn_n 1111->1010 in one cycle -> single pulse 1011 (left beats right); btn_state=1010; no 1110 pulse afterward.
- btn_n=1101 held while reset is pulsed 1 cycle mid-debounce -> after reset, exactly one 1101 pulse, 7 cycles after reset deasserts.
- AUTO_REPEAT_EN, btn_n=1110 held 60 cycles -> initial 1110 pulse, then repeats 20 cycles after btn_state falls and every 8 cycles after that; without the macro, only the initial pulse.
